// File: rtl/demux1x4_buffered.sv
// Steers one input word into one of four holding slots (A-D); each slot holds its word until the consumer acks it.
// One cycle from accept to slot output. in_ready drops while the addressed slot is full and not being acked that cycle.
module demux1x4_buffered #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_d,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ack,
  output logic [CNT_W-1:0] xfer_count
);

  logic [WIDTH-1:0] slot_q [4];
  logic             xfer;

  // An ack in the same cycle frees the slot, so a full slot can be refilled back-to-back.
  assign in_ready = ~out_valid[in_sel] | out_ack[in_sel];
  assign xfer     = in_valid & in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        slot_q[i] <= '0;
      end
      out_valid  <= '0;
      xfer_count <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (xfer && (in_sel == 2'(i))) begin
          slot_q[i]    <= in_data;
          out_valid[i] <= 1'b1;
        end else if (out_ack[i] && out_valid[i]) begin
          out_valid[i] <= 1'b0;
        end
      end
      if (xfer) begin
        xfer_count <= xfer_count + 1'b1;
      end
    end
  end

  assign out_a = slot_q[0];
  assign out_b = slot_q[1];
  assign out_c = slot_q[2];
  assign out_d = slot_q[3];

endmodule
